// File: rtl/spi_host_ctrl.sv
// SPI initiator (mode 0) serialising one {rw,addr}+data register frame per request.
// Optional build macro SPI_HOST_CTRL_LOOPBACK_EN adds a 'loopback' input that captures MOSI instead of MISO.
module spi_host_ctrl #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int CLK_DIV    = 4
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  ena,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0]      req_wdata,
  output logic                  rsp_valid,
  output logic [WIDTH-1:0]      rsp_rdata,
  output logic                  spi_cs_n,
  output logic                  spi_clk,
  output logic                  spi_mosi,
`ifdef SPI_HOST_CTRL_LOOPBACK_EN
  input  logic                  loopback,
`endif
  input  logic                  spi_miso
);

  localparam int FRAME_W = 8 + WIDTH;
  localparam int EDGES   = 2 * FRAME_W;
  localparam int EDGE_W  = $clog2(EDGES);
  localparam int DIV_W   = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } state_t;

  state_t               state;
  logic [DIV_W-1:0]     div_cnt;
  logic [EDGE_W-1:0]    edge_cnt;
  logic                 rsp_pend;
  logic [FRAME_W-1:0]   shreg;
  logic [WIDTH-1:0]     cap;
  logic [FRAME_W-1:0]   frame;
  logic                 div_done;
  logic                 accept;
  logic                 rise_evt;
  logic                 fall_evt;
  logic                 cap_bit;

  assign div_done  = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign req_ready = (state == IDLE) & ena;
  assign accept    = req_valid & req_ready;
  // A pulse that lands while disabled stays pending in rsp_pend until ena returns.
  assign rsp_valid = rsp_pend & ena;

  assign rise_evt = ((state == SETUP) || ((state == SHIFT) && !spi_clk)) && div_done;
  assign fall_evt = (state == SHIFT) && spi_clk && div_done;

`ifdef SPI_HOST_CTRL_LOOPBACK_EN
  assign cap_bit = loopback ? spi_mosi : spi_miso;
`else
  assign cap_bit = spi_miso;
`endif

  always_comb begin
    frame              = {8'(req_addr), (req_write ? req_wdata : {WIDTH{1'b0}})};
    frame[FRAME_W-1]   = req_write;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state     <= IDLE;
      div_cnt   <= '0;
      edge_cnt  <= '0;
      spi_cs_n  <= 1'b1;
      spi_clk   <= 1'b0;
      spi_mosi  <= 1'b0;
      rsp_pend  <= 1'b0;
      rsp_rdata <= '0;
    end else if (ena) begin
      rsp_pend <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            state    <= SETUP;
            div_cnt  <= '0;
            spi_cs_n <= 1'b0;
            spi_mosi <= frame[FRAME_W-1];
          end
        end
        SETUP: begin
          if (div_done) begin
            div_cnt  <= '0;
            edge_cnt <= '0;
            spi_clk  <= 1'b1;
            state    <= SHIFT;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (div_done) begin
            div_cnt  <= '0;
            spi_clk  <= ~spi_clk;
            edge_cnt <= edge_cnt + 1'b1;
            // edge_cnt indexes the edge just made; the final fall keeps MOSI on the last bit
            if (spi_clk) begin
              if (edge_cnt == EDGE_W'(EDGES - 2)) begin
                state <= HOLD;
              end else begin
                spi_mosi <= shreg[FRAME_W-1];
              end
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        HOLD: begin
          if (div_done) begin
            div_cnt   <= '0;
            spi_cs_n  <= 1'b1;
            spi_mosi  <= 1'b0;
            rsp_pend  <= 1'b1;
            rsp_rdata <= cap;
            state     <= GAP;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        GAP: begin
          if (div_done) begin
            div_cnt <= '0;
            state   <= IDLE;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Shift and capture registers carry data only; every frame reloads or fully overwrites them.
  always_ff @(posedge clk) begin
    if (ena) begin
      if (accept) begin
        shreg <= {frame[FRAME_W-2:0], 1'b0};
      end else if (fall_evt) begin
        shreg <= {shreg[FRAME_W-2:0], 1'b0};
      end
      if (rise_evt) begin
        cap <= {cap[WIDTH-2:0], cap_bit};
      end
    end
  end

endmodule

// File: tb/tb_spi_host_ctrl.sv
// Directed bench for spi_host_ctrl at CLK_DIV=4 with a mode-0 responder model on MISO.
// Times below are cycle offsets from the accept cycle T.
module tb_spi_host_ctrl;

  logic       clk = 1'b0;
  logic       rstb = 1'b0;
  logic       ena = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_write = 1'b0;
  logic [2:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       spi_cs_n;
  logic       spi_clk;
  logic       spi_mosi;
  logic       spi_miso;
`ifdef SPI_HOST_CTRL_LOOPBACK_EN
  logic       loopback = 1'b0;
`endif

  always #5 clk = ~clk;

  spi_host_ctrl #(.WIDTH(8), .ADDR_WIDTH(3), .CLK_DIV(4)) dut (
    .clk       (clk),
    .rstb      (rstb),
    .ena       (ena),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .spi_cs_n  (spi_cs_n),
    .spi_clk   (spi_clk),
    .spi_mosi  (spi_mosi),
`ifdef SPI_HOST_CTRL_LOOPBACK_EN
    .loopback  (loopback),
`endif
    .spi_miso  (spi_miso)
  );

  // Responder: presents resp_byte MSB first during the second byte, changing after each fall.
  logic [7:0] resp_byte = 8'h00;
  int         ridx = 0;
  always @(negedge spi_clk or posedge spi_cs_n) begin
    if (spi_cs_n) ridx <= 0;
    else          ridx <= ridx + 1;
  end
  assign spi_miso = (!spi_cs_n && ridx >= 8 && ridx < 16) ? resp_byte[15 - ridx] : 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  int          r_cs_fall, r_cs_fall2, r_cs_rise, r_rise1, r_rsp_t, r_ready_t;
  int          r_cs_low, r_rises, r_rsp_cnt, r_hold_err;
  logic [15:0] r_mosi;
  logic [7:0]  r_rdata;

  task automatic run_frame(input logic wr, input logic [2:0] addr, input logic [7:0] wd,
                           input logic [7:0] resp, input int drop_t, input int drop_len,
                           input int rst_rise, input bit keep_valid, input int max_t);
    int t, wait_cyc, rst_t;
    logic prev_clk, prev_cs, h_clk, h_cs, h_mosi;
    bit stop_on_ready;
    r_cs_fall = -1; r_cs_fall2 = -1; r_cs_rise = -1; r_rise1 = -1; r_rsp_t = -1; r_ready_t = -1;
    r_cs_low = 0; r_rises = 0; r_rsp_cnt = 0; r_hold_err = 0; r_mosi = '0; r_rdata = '0;
    h_clk = 1'b0; h_cs = 1'b1; h_mosi = 1'b0;
    @(negedge clk);
    req_write = wr; req_addr = addr; req_wdata = wd; resp_byte = resp; req_valid = 1'b1;
    wait_cyc = 0;
    while (!req_ready && wait_cyc < 100) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (!req_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    t = 0; rst_t = -1;
    prev_clk = spi_clk; prev_cs = spi_cs_n;
    stop_on_ready = !keep_valid && (rst_rise == 0);
    while (t < max_t) begin
      @(negedge clk);
      t++;
      if (!keep_valid) req_valid = 1'b0;
      if (!spi_cs_n) r_cs_low++;
      if (!spi_cs_n && prev_cs) begin
        if (r_cs_fall < 0) r_cs_fall = t;
        else if (r_cs_fall2 < 0) r_cs_fall2 = t;
      end
      if (spi_cs_n && !prev_cs && r_cs_rise < 0) r_cs_rise = t;
      if (spi_clk && !prev_clk) begin
        r_rises++;
        r_mosi = {r_mosi[14:0], spi_mosi};
        if (r_rise1 < 0) r_rise1 = t;
      end
      if (rsp_valid) begin
        r_rsp_cnt++;
        if (r_rsp_t < 0) r_rsp_t = t;
        r_rdata = rsp_rdata;
      end
      if (drop_t > 0 && t > drop_t && t <= drop_t + drop_len) begin
        if (spi_clk !== h_clk || spi_cs_n !== h_cs || spi_mosi !== h_mosi || rsp_valid !== 1'b0)
          r_hold_err++;
      end
      prev_clk = spi_clk; prev_cs = spi_cs_n;
      if (drop_t > 0 && t == drop_t) begin
        ena = 1'b0;
        h_clk = spi_clk; h_cs = spi_cs_n; h_mosi = spi_mosi;
      end
      if (drop_t > 0 && t == drop_t + drop_len) ena = 1'b1;
      if (rst_rise > 0 && rst_t < 0 && r_rises == rst_rise) begin
        rstb = 1'b0;
        rst_t = t;
        #1;
        check("rst_async_cs_n", {31'd0, spi_cs_n}, 32'd1);
        check("rst_async_clk", {31'd0, spi_clk}, 32'd0);
        check("rst_async_mosi", {31'd0, spi_mosi}, 32'd0);
        check("rst_async_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        prev_clk = spi_clk; prev_cs = spi_cs_n;
      end
      if (rst_t > 0 && t == rst_t + 3) rstb = 1'b1;
      if (stop_on_ready && req_ready) begin
        r_ready_t = t;
        break;
      end
    end
    req_valid = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic [2:0]  addr;
    logic [7:0]  wdata;
    logic [7:0]  resp;
    logic [15:0] mosi;
    logic [7:0]  rdata;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{wr: 1'b1, addr: 3'd2, wdata: 8'hA5, resp: 8'h77, mosi: 16'h82A5, rdata: 8'h77};
    vecs[1] = '{wr: 1'b0, addr: 3'd4, wdata: 8'hEE, resp: 8'h3C, mosi: 16'h0400, rdata: 8'h3C};
    vecs[2] = '{wr: 1'b1, addr: 3'd7, wdata: 8'h01, resp: 8'hFF, mosi: 16'h8701, rdata: 8'hFF};
    vecs[3] = '{wr: 1'b0, addr: 3'd0, wdata: 8'h00, resp: 8'h81, mosi: 16'h0000, rdata: 8'h81};
    vecs[4] = '{wr: 1'b1, addr: 3'd5, wdata: 8'hFF, resp: 8'h00, mosi: 16'h85FF, rdata: 8'h00};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_cs_n", {31'd0, spi_cs_n}, 32'd1);
    check("reset_spi_clk", {31'd0, spi_clk}, 32'd0);
    check("reset_mosi", {31'd0, spi_mosi}, 32'd0);
    check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
    check("reset_req_ready", {31'd0, req_ready}, 32'd1);
    ena = 1'b0;
    #1;
    check("ready_gated_by_ena", {31'd0, req_ready}, 32'd0);
    ena = 1'b1;
    @(negedge clk);
    rstb = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      run_frame(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].resp, 0, 0, 0, 1'b0, 400);
      check($sformatf("v%0d_mosi", i), {16'd0, r_mosi}, {16'd0, vecs[i].mosi});
      check($sformatf("v%0d_rdata", i), {24'd0, r_rdata}, {24'd0, vecs[i].rdata});
      check($sformatf("v%0d_cs_fall", i), r_cs_fall, 32'd1);
      check($sformatf("v%0d_first_rise", i), r_rise1, 32'd5);
      check($sformatf("v%0d_rises", i), r_rises, 32'd16);
      check($sformatf("v%0d_cs_low", i), r_cs_low, 32'd132);
      check($sformatf("v%0d_rsp_t", i), r_rsp_t, 32'd133);
      check($sformatf("v%0d_rsp_cnt", i), r_rsp_cnt, 32'd1);
      check($sformatf("v%0d_ready_t", i), r_ready_t, 32'd137);
    end

    // ena low for 10 cycles just after the 5th rising edge
    run_frame(1'b1, 3'd3, 8'hC3, 8'h5A, 37, 10, 0, 1'b0, 400);
    check("ena_mid_hold", r_hold_err, 32'd0);
    check("ena_mid_mosi", {16'd0, r_mosi}, 32'h000083C3);
    check("ena_mid_rdata", {24'd0, r_rdata}, 32'h5A);
    check("ena_mid_cs_low", r_cs_low, 32'd142);
    check("ena_mid_rsp_t", r_rsp_t, 32'd143);
    check("ena_mid_ready_t", r_ready_t, 32'd147);

    // ena low across the response point: pulse deferred until ena returns
    run_frame(1'b0, 3'd6, 8'h00, 8'h96, 132, 4, 0, 1'b0, 400);
    check("ena_rsp_hold", r_hold_err, 32'd0);
    check("ena_rsp_t", r_rsp_t, 32'd137);
    check("ena_rsp_cnt", r_rsp_cnt, 32'd1);
    check("ena_rsp_rdata", {24'd0, r_rdata}, 32'h96);
    check("ena_rsp_ready_t", r_ready_t, 32'd141);

    // Reset after the 8th rising edge aborts the frame silently
    run_frame(1'b1, 3'd1, 8'h33, 8'h44, 0, 0, 8, 1'b0, 200);
    check("rst_mid_no_rsp", r_rsp_cnt, 32'd0);
    check("rst_mid_rdata_cleared", {24'd0, rsp_rdata}, 32'd0);
    run_frame(1'b0, 3'd2, 8'h00, 8'hE7, 0, 0, 0, 1'b0, 400);
    check("post_rst_mosi", {16'd0, r_mosi}, 32'h00000200);
    check("post_rst_rdata", {24'd0, r_rdata}, 32'hE7);
    check("post_rst_rsp_t", r_rsp_t, 32'd133);

    // Back-to-back with req_valid held high
    run_frame(1'b1, 3'd1, 8'h3C, 8'h55, 0, 0, 0, 1'b1, 273);
    check("b2b_rsp_cnt", r_rsp_cnt, 32'd2);
    check("b2b_cs_fall1", r_cs_fall, 32'd1);
    check("b2b_cs_rise1", r_cs_rise, 32'd133);
    check("b2b_cs_fall2", r_cs_fall2, 32'd138);
    check("b2b_gap_ge4", {31'd0, (r_cs_fall2 - r_cs_rise) >= 4}, 32'd1);
    check("b2b_mosi2", {16'd0, r_mosi}, 32'h0000813C);
    check("b2b_rdata2", {24'd0, r_rdata}, 32'h55);

`ifdef SPI_HOST_CTRL_LOOPBACK_EN
    loopback = 1'b1;
    run_frame(1'b1, 3'd2, 8'h5A, 8'hFF, 0, 0, 0, 1'b0, 400);
    check("lb_write_rdata", {24'd0, r_rdata}, 32'h5A);
    run_frame(1'b0, 3'd2, 8'h00, 8'hFF, 0, 0, 0, 1'b0, 400);
    check("lb_read_rdata", {24'd0, r_rdata}, 32'h00);
    loopback = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_host_ctrl.md
Name: spi_host_ctrl

Overview:
- SPI controller (initiator) that drives the RSA peripheral's SPI register interface from a parallel request/response port.
- Serialises one register write or read per request as a 16-bit frame.
- Used as bench/host-side logic and for chip-to-chip bring-up of the RSA peripheral.
- Sits between a host sequencer and the SPI pins spi_cs_n/spi_clk/spi_mosi/spi_miso.

Parameters:
- WIDTH, 8, data byte width; frame length is 8+WIDTH bits.
- ADDR_WIDTH, 3, register address width, max 7.
- CLK_DIV, 4, clk cycles per SPI half-period; legal range 2..255.

Ports:
- clk  in  1  system clock
- rstb  in  1  asynchronous active-low reset
- ena  in  1  block enable; low freezes all state
- req_valid  in  1  request present
- req_ready  out  1  request accepted when valid&ready
- req_write  in  1  1=write, 0=read
- req_addr  in  ADDR_WIDTH  register address
- req_wdata  in  WIDTH  write data
- rsp_valid  out  1  one-cycle pulse at end of every frame
- rsp_rdata  out  WIDTH  second-byte MISO capture, valid with rsp_valid
- spi_cs_n  out  1  chip select, active low
- spi_clk  out  1  SPI clock, mode 0 (CPOL=0, CPHA=0)
- spi_mosi  out  1  serial data out, MSB first
- spi_miso  in  1  serial data in

Behaviour:
- Frame format: byte0 = {rw, zeros, addr} with rw at bit 7 and addr in bits ADDR_WIDTH-1:0; byte1 = wdata for writes, all zeros for reads. Both bytes MSB first.
- Responder returns read data on MISO during byte1.
- Reset values: spi_cs_n=1, spi_clk=0, spi_mosi=0, rsp_valid=0, rsp_rdata=0, state IDLE.
- req_ready = (state==IDLE) & ena, combinational.
- States:
  - IDLE: on accept at edge T, latch frame into shift register and go to SETUP.
  - SETUP: spi_cs_n=0 and spi_mosi=frame bit 15 from T+1; hold CLK_DIV cycles.
  - SHIFT: spi_clk toggles every CLK_DIV cycles; 16 rising and 16 falling edges.
    - MISO sampled into capture register on the same clk edge that drives spi_clk 0→1.
    - MOSI advances one bit on each falling edge, except after the 16th.
  - HOLD: spi_clk=0 for CLK_DIV cycles, then spi_cs_n=1, spi_mosi=0, rsp_valid=1 for one cycle. rsp_rdata = last 8 captured bits; updated for writes too.
  - GAP: spi_cs_n high for CLK_DIV cycles, then IDLE.
- Timing, accept at T:
  - cs low at T+1.
  - First rise at T+1+CLK_DIV.
  - Last fall at T+1+32·CLK_DIV.
  - cs high and rsp_valid at T+1+33·CLK_DIV.
  - req_ready at T+1+34·CLK_DIV.
  - For CLK_DIV=4: T+1, T+5, T+129, T+133, T+137.
- Counters: half-period counter counts 0..CLK_DIV-1; edge counter 0..31, no wrap beyond.
- ena low: FSM, counters, shift and capture registers freeze; SPI outputs hold current level; rsp_valid forced 0 and the pending pulse is emitted when ena returns.
- req_valid changes while busy are ignored; the request fields are captured only at accept.
- Reset mid-frame: immediate return to reset values; no rsp_valid for the aborted frame.

Optional Feature:
- Macro: SPI_HOST_CTRL_LOOPBACK_EN.
- Defined: adds input port loopback (1 bit). When loopback=1, the capture path samples spi_mosi internally instead of spi_miso. A read frame then returns 0x00 and a write frame returns wdata.
- Not defined: no loopback port; capture always from spi_miso.

Test Plan:
- Write addr=2, wdata=0xA5, CLK_DIV=4 → MOSI sampled on rising edges = 0x82 then 0xA5; cs low for 132 clk cycles; rsp_valid once at T+133.
- Read addr=4, responder model drives 0x3C on MISO in byte1 → MOSI 0x04,0x00; rsp_rdata=0x3C with rsp_valid.
- Back-to-back requests with req_valid held high → second accept at T+137; cs high ≥4 cycles between frames; two rsp_valid pulses.
- ena dropped for 10 cycles after the 5th rising edge → spi_clk/cs/mosi hold; total frame stretched by exactly 10 cycles; data intact.
- rstb asserted after 8th rising edge → cs_n=1, spi_clk=0 asynchronously; no rsp_valid; next request completes normally.
- LOOPBACK_EN with loopback=1, write 0x5A → rsp_rdata=0x5A; read → 0x00.
